// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: op-code constants,
// arbiter FSM encoding and the legal-op check.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Upper half of the select space is reserved.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: result F and zeroflag from operands A/B and select S.
// Shifts use the low log2(WIDTH) bits of B; reserved selects yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  output logic [WIDTH-1:0] F,
  output logic             zeroflag
);

  localparam int SHW = $clog2(WIDTH);

  // Operation select
  always_comb begin
    F = '0;
    case (S)
      ALU_ADD: F = A + B;
      ALU_SUB: F = A - B;
      ALU_XOR: F = A ^ B;
      ALU_SLT: F = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL: F = A << B[SHW-1:0];
      ALU_SRL: F = A >> B[SHW-1:0];
      ALU_OR:  F = A | B;
      ALU_AND: F = A & B;
      default: F = '0;
    endcase
  end

  assign zeroflag = (F == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// returning a registered result tagged with the owner ID.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0] alu_f;
  logic             alu_zero_unused;
  logic             window_s, grant_s, accept_s;

  alu #(.WIDTH(WIDTH)) u_alu (
    .A        (a_q),
    .B        (b_q),
    .S        (op_q),
    .F        (alu_f),
    .zeroflag (alu_zero_unused)
  );

  // Grant: sole requester wins, contention goes to the one not served last
  always_comb begin
    window_s = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s = window_s && (req0_valid || req1_valid) && !rst;
  end

  assign req0_ready = accept_s && !grant_s;
  assign req1_ready = accept_s && grant_s;

  // Next-state, operand latch and response register computation
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_f_d     = rsp_f_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;

    if (accept_s) begin
      a_d          = grant_s ? req1_a  : req0_a;
      b_d          = grant_s ? req1_b  : req0_b;
      op_d         = grant_s ? req1_op : req0_op;
      id_d         = grant_s;
      last_grant_d = grant_s;
    end else begin
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = accept_s ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        // Illegal ops force a zero result; zero flag follows the stored result
        rsp_f_d     = op_is_legal(op_q) ? alu_f : '0;
        rsp_zero_d  = (rsp_f_d == '0);
        rsp_err_d   = ~op_is_legal(op_q);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept_s ? ST_EXEC : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 4'b0000;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_f_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_f_q      <= rsp_f_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked
// each cycle against a transaction-level model of grant, latency and result.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [W-1:0] rsp_f;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one op in flight, response visible from the second sample after accept
  bit           m_inflight, m_vis;
  int           m_last;
  logic         m_id, m_err;
  logic [W-1:0] m_f;
  int           g_log[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic [W-1:0] f;
    logic         err;
    err = 1'b0;
    case (op)
      4'd0:    f = a + b;
      4'd1:    f = a - b;
      4'd2:    f = a ^ b;
      4'd3:    f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    f = a << b[4:0];
      4'd5:    f = a >> b[4:0];
      4'd6:    f = a | b;
      4'd7:    f = a & b;
      default: begin f = '0; err = 1'b1; end
    endcase
    return {err, f};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model, predict the edge, drop accepted valids
  task automatic step();
    int         g;
    bit         win, acc, hs;
    logic [W:0] r;
    #1;
    cyc++;
    if (rst) begin
      chk("ready0_in_reset", req0_ready, '0);
      chk("ready1_in_reset", req1_ready, '0);
      @(posedge clk);
      m_last = 1; m_inflight = 0; m_vis = 0;
      @(negedge clk);
      return;
    end
    chk("busy", busy, m_inflight);
    chk("rsp_valid", rsp_valid, m_vis);
    if (m_vis) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_f", rsp_f, m_f);
      chk("rsp_zero", rsp_zero, (m_f == '0));
      chk("rsp_err", rsp_err, m_err);
    end
    win = !m_inflight || (m_vis && rsp_ready);
    g   = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
    acc = win && (req0_valid || req1_valid);
    chk("req0_ready", req0_ready, (acc && g == 0));
    chk("req1_ready", req1_ready, (acc && g == 1));
    hs = m_vis && rsp_ready;
    if (m_inflight && !m_vis) begin
      m_vis = 1;
    end else begin
      if (hs) begin m_inflight = 0; m_vis = 0; end
      if (acc) begin
        r = (g == 0) ? ref_alu(req0_a, req0_b, req0_op) : ref_alu(req1_a, req1_b, req1_op);
        m_inflight = 1; m_vis = 0;
        m_id = g[0]; m_f = r[W-1:0]; m_err = r[W]; m_last = g;
        g_log.push_back(g);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (acc) begin
      if (g == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
    end
  endtask

  task automatic expect_rsp(input string tag, input logic id, input logic [W-1:0] f,
                            input logic zero, input logic err, input int lat);
    int n = 0;
    while (!rsp_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_f"}, rsp_f, f);
    chk({tag, "_zero"}, rsp_zero, zero);
    chk({tag, "_err"}, rsp_err, err);
    if (lat >= 0) chk({tag, "_latency"}, n, lat);
  endtask

  task automatic set0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
  endtask

  task automatic set1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   b2b_op  [4];
    logic [W-1:0] b2b_exp [4];
    int           issued, got, last_cyc, n, sz;

    b2b_op  = '{4'd4, 4'd5, 4'd6, 4'd7};
    b2b_exp = '{32'h23456780, 32'h01234567, 32'h1234567C, 32'h00000000};
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    m_last = 1; m_inflight = 0; m_vis = 0;

    // Reset with a request pending: readys stay low
    @(negedge clk);
    set0(32'h1, 32'h2, 4'd0);
    set1(32'h3, 32'h4, 4'd0);
    repeat (3) step();
    rst = 1'b0; req0_valid = 0; req1_valid = 0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_f", rsp_f, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready0", req0_ready, 0);
    chk("reset_ready1", req1_ready, 0);

    // Single ADD
    set0(32'h12345678, 32'h99ADBEF0, 4'd0);
    step();
    expect_rsp("add", 1'b0, 32'hABE21568, 1'b0, 1'b0, 1);
    step();

    // Contention right after reset: req0 first, then req1
    do_reset();
    set0(32'h12345678, 32'h99ADBEF0, 4'd1);
    set1(32'h12345678, 32'h99ADBEF0, 4'd2);
    step();
    chk("cont_req1_waiting", req1_valid, 1);
    expect_rsp("sub", 1'b0, 32'h78869788, 1'b0, 1'b0, 1);
    step();
    chk("cont_gap", rsp_valid, 0);
    expect_rsp("xor", 1'b1, 32'h8B99E888, 1'b0, 1'b0, 1);
    step();

    // Sustained contention alternates grants
    g_log.delete();
    for (int i = 0; i < 6; i++) begin
      if (!req0_valid) set0($urandom, $urandom, 4'($urandom_range(0, 7)));
      if (!req1_valid) set1($urandom, $urandom, 4'($urandom_range(0, 7)));
      sz = g_log.size();
      n  = 0;
      while (g_log.size() == sz && n < 6) begin step(); n++; end
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", g_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < g_log.size()) chk("alt_grant", g_log[i], i % 2);
    end
    repeat (3) step();

    // Backpressure on a pending SLT with a waiting request
    rsp_ready = 0;
    set0(32'h12345678, 32'h99ADBEF0, 4'd3);
    step();
    expect_rsp("slt", 1'b0, 32'h0, 1'b1, 1'b0, 1);
    set1(32'hFFFF0000, 32'h0F0F0F0F, 4'd7);
    repeat (5) step();
    chk("bp_hold_f", rsp_f, 0);
    chk("bp_hold_valid", rsp_valid, 1);
    rsp_ready = 1;
    #1;
    chk("bp_release_ready1", req1_ready, 1);
    step();
    chk("bp_gap", rsp_valid, 0);
    expect_rsp("bp_next", 1'b1, 32'h0F0F0000, 1'b0, 1'b0, 1);
    step();

    // Zero result and illegal op
    set0(32'h55, 32'h55, 4'd1);
    step();
    expect_rsp("sub_zero", 1'b0, 32'h0, 1'b1, 1'b0, 1);
    step();
    set1(32'hDEADBEEF, 32'h1, 4'b1010);
    step();
    expect_rsp("illegal", 1'b1, 32'h0, 1'b1, 1'b1, 1);
    step();

    // Reset during EXEC drops the op; contention then favours req0
    set1(32'h12345678, 32'h1, 4'd0);
    step();
    chk("midrst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_f", rsp_f, 0);
    chk("midrst_idle", busy, 0);
    repeat (3) step();
    set0(32'h12345678, 32'h99ADBEF0, 4'd1);
    set1(32'h12345678, 32'h99ADBEF0, 4'd2);
    step();
    chk("midrst_first_req0", req0_valid, 0);
    expect_rsp("midrst_sub", 1'b0, 32'h78869788, 1'b0, 1'b0, 1);
    step();
    expect_rsp("midrst_xor", 1'b1, 32'h8B99E888, 1'b0, 1'b0, 1);
    step();

    // Back-to-back ops from req1 with rsp_ready held high
    issued = 0; got = 0; last_cyc = 0;
    req1_a = 32'h12345678; req1_b = 32'h4;
    for (int k = 0; k < 40 && got < 4; k++) begin
      if (!req1_valid && issued < 4) begin
        set1(32'h12345678, 32'h4, b2b_op[issued]);
        issued++;
      end
      if (rsp_valid) begin
        chk("b2b_f", rsp_f, b2b_exp[got]);
        chk("b2b_zero", rsp_zero, (got == 3));
        if (got > 0) chk("b2b_spacing", cyc - last_cyc, 2);
        last_cyc = cyc;
        got++;
      end
      step();
    end
    chk("b2b_count", got, 4);
    req1_valid = 0;
    repeat (3) step();

    // Random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) set0($urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!req1_valid && $urandom_range(0, 1) == 1) set1($urandom, $urandom, 4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
